// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: clock-enable sequencer for the single-cycle CPU (free-run, single-step, PC breakpoint).
// Breakpoint logic is compiled in only when CPU_CTRL_BP_EN is defined; the ports exist in both builds.

module cpu_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int RUN_DIV      = 25000000,
  parameter int CYC_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_n_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             cpu_en_o,
  output logic [1:0]       state_o,
  output logic             bp_hit_o,
  output logic [CYC_W-1:0] icount_o
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t           state_q;
  logic             cpu_en_q;
  logic             bp_hit_q;
  logic [CYC_W-1:0] icount_q;
  logic [DIV_W-1:0] div_q;
  logic             skip_bp_q;

  logic             key_s1_q;
  logic             key_s2_q;
  logic             key_db_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             step_req_q;
  logic             bp_match;

  // Key synchronizer; released (1) is the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= step_n_i;
      key_s2_q <= key_s1_q;
    end
  end

  // Any return of the synced level to the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      step_req_q <= 1'b0;
    end else begin
      step_req_q <= 1'b0;
      if (key_s2_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        key_db_q   <= key_s2_q;
        db_cnt_q   <= '0;
        step_req_q <= ~key_s2_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef CPU_CTRL_BP_EN
  assign bp_match = bp_en_i & (pc_i == bp_addr_i);
`else
  logic bp_unused;
  assign bp_unused = ^{bp_en_i, bp_addr_i, pc_i};
  assign bp_match  = 1'b0;
`endif

  // cpu_en_q is raised together with the decision edge, so icount_q counts the pulse it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cpu_en_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      icount_q  <= '0;
      div_q     <= '0;
      skip_bp_q <= 1'b0;
    end else begin
      cpu_en_q <= 1'b0;
      bp_hit_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_q   <= S_RUN;
            div_q     <= '0;
            skip_bp_q <= 1'b1;
          end else if (step_req_q) begin
            state_q  <= S_STEP;
            cpu_en_q <= 1'b1;
            icount_q <= icount_q + CYC_W'(1);
          end
        end
        S_RUN: begin
          if (!run_i) begin
            state_q <= S_IDLE;
          end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bp_match && !skip_bp_q) begin
              state_q  <= S_BREAK;
              bp_hit_q <= 1'b1;
            end else begin
              cpu_en_q  <= 1'b1;
              icount_q  <= icount_q + CYC_W'(1);
              skip_bp_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_STEP: begin
          state_q <= S_IDLE;
        end
        S_BREAK: begin
          if (!run_i) begin
            state_q <= S_IDLE;
          end else if (step_req_q) begin
            state_q  <= S_STEP;
            cpu_en_q <= 1'b1;
            icount_q <= icount_q + CYC_W'(1);
          end else begin
            bp_hit_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_en_o = cpu_en_q;
  assign state_o  = state_q;
  assign bp_hit_o = bp_hit_q;
  assign icount_o = icount_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: run table, reset/step/priority/breakpoint/wrap sequences, then random traffic
// checked against a reference model derived from the controller's rules.

module tb_cpu_run_ctrl;

  localparam int PC_W  = 8;
  localparam int DEB   = 4;
  localparam int DIV   = 3;
  localparam int CYC_W = 8;
  localparam int EXP_W = 4 + CYC_W;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BREAK = 2'b11;
`ifdef CPU_CTRL_BP_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run_i;
  logic             step_n_i;
  logic             bp_en_i;
  logic [PC_W-1:0]  bp_addr_i;
  logic [PC_W-1:0]  pc_i;
  logic             cpu_en_o;
  logic [1:0]       state_o;
  logic             bp_hit_o;
  logic [CYC_W-1:0] icount_o;

  cpu_run_ctrl #(.PC_W(PC_W), .DEBOUNCE_CYC(DEB), .RUN_DIV(DIV), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_n_i(step_n_i), .bp_en_i(bp_en_i),
    .bp_addr_i(bp_addr_i), .pc_i(pc_i), .cpu_en_o(cpu_en_o), .state_o(state_o),
    .bp_hit_o(bp_hit_o), .icount_o(icount_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model state
  logic [1:0]       m_state;
  bit               m_en, m_hit, m_skip, m_db, m_step_req;
  logic [CYC_W-1:0] m_icount;
  int               m_run_age;
  bit               key_hist[$];
  bit               auto_pc;
  logic [PC_W-1:0]  pc_mask;

  typedef struct {
    logic       run;
    logic       step_n;
    logic [1:0] st;
    logic       en;
    logic [7:0] ic;
  } vec_t;
  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_en = 0; m_hit = 0; m_skip = 0; m_db = 1; m_step_req = 0;
    m_icount = '0; m_run_age = 0;
    key_hist.delete();
    for (int k = 0; k <= DEB; k++) key_hist.push_back(1'b1);
  endtask

  // One clock edge of the controller's rules, applied to the inputs currently driven.
  task automatic model_edge();
    bit all_same, new_db, match, n_en, n_hit, n_skip, tick_now;
    logic [1:0] n_state;
    int n_age;
    // the filter sees the key level from two edges back; it is accepted after DEB equal samples
    all_same = 1;
    for (int k = 2; k <= DEB; k++) if (key_hist[k] != key_hist[1]) all_same = 0;
    new_db = m_db;
    if (all_same && key_hist[1] != m_db) new_db = key_hist[1];
    match = BP_ON && (bp_en_i == 1'b1) && (pc_i == bp_addr_i);
    n_state = m_state; n_en = 0; n_hit = 0; n_skip = m_skip; n_age = m_run_age;
    case (m_state)
      ST_IDLE: begin
        if (run_i) begin n_state = ST_RUN; n_age = 0; n_skip = 1; end
        else if (m_step_req) begin n_state = ST_STEP; n_en = 1; end
      end
      ST_RUN: begin
        if (!run_i) n_state = ST_IDLE;
        else begin
          tick_now = (m_run_age % DIV) == DIV - 1;
          if (tick_now) begin
            if (match && !m_skip) begin n_state = ST_BREAK; n_hit = 1; end
            else begin n_en = 1; n_skip = 0; end
          end
          n_age = m_run_age + 1;
        end
      end
      ST_STEP: n_state = ST_IDLE;
      default: begin
        if (!run_i) n_state = ST_IDLE;
        else if (m_step_req) begin n_state = ST_STEP; n_en = 1; end
        else n_hit = 1;
      end
    endcase
    m_step_req = m_db && !new_db;
    m_db = new_db;
    key_hist.push_front(step_n_i);
    void'(key_hist.pop_back());
    m_state = n_state; m_en = n_en; m_hit = n_hit; m_skip = n_skip; m_run_age = n_age;
    m_icount = m_icount + CYC_W'(n_en);
    exp_q.push_back({m_state, m_en, m_hit, m_icount});
  endtask

  task automatic tick(input string tag);
    logic [EXP_W-1:0] e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s.state", tag), 32'(state_o), 32'(e[EXP_W-1 -: 2]));
    check($sformatf("%s.en", tag), 32'(cpu_en_o), 32'(e[CYC_W+1]));
    check($sformatf("%s.bp_hit", tag), 32'(bp_hit_o), 32'(e[CYC_W]));
    check($sformatf("%s.icount", tag), 32'(icount_o), 32'(e[CYC_W-1:0]));
    if (cpu_en_o === 1'b1) n_pulses++;
    if (auto_pc && m_en) pc_i = (pc_i + PC_W'(1)) & pc_mask;
  endtask

  initial begin
    bit found, wrapped;
    int key_hold;

    vt[0]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd0};
    vt[1]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd0};
    vt[2]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd0};
    vt[3]  = '{1'b1, 1'b1, ST_RUN,  1'b1, 8'd1};
    vt[4]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd1};
    vt[5]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd1};
    vt[6]  = '{1'b1, 1'b1, ST_RUN,  1'b1, 8'd2};
    vt[7]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd2};
    vt[8]  = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd2};
    vt[9]  = '{1'b1, 1'b1, ST_RUN,  1'b1, 8'd3};
    vt[10] = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd3};
    vt[11] = '{1'b1, 1'b1, ST_RUN,  1'b0, 8'd3};
    vt[12] = '{1'b1, 1'b1, ST_RUN,  1'b1, 8'd4};
    vt[13] = '{1'b0, 1'b1, ST_IDLE, 1'b0, 8'd4};
    vt[14] = '{1'b0, 1'b1, ST_IDLE, 1'b0, 8'd4};

    rst_n = 1'b0; run_i = 1'b0; step_n_i = 1'b1; bp_en_i = 1'b0;
    bp_addr_i = '0; pc_i = '0; auto_pc = 1'b0; pc_mask = '1;
    repeat (2) @(negedge clk);
    check("reset.state", 32'(state_o), 32'(ST_IDLE));
    check("reset.en", 32'(cpu_en_o), 32'd0);
    check("reset.bp_hit", 32'(bp_hit_o), 32'd0);
    check("reset.icount", 32'(icount_o), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // free-run table
    for (int i = 0; i < 15; i++) begin
      run_i = vt[i].run;
      step_n_i = vt[i].step_n;
      tick("run_tbl");
      check($sformatf("tbl%0d.state", i), 32'(state_o), 32'(vt[i].st));
      check($sformatf("tbl%0d.en", i), 32'(cpu_en_o), 32'(vt[i].en));
      check($sformatf("tbl%0d.icount", i), 32'(icount_o), 32'(vt[i].ic));
    end

    // asynchronous reset in the middle of a pulse
    run_i = 1'b1;
    repeat (4) tick("pre_reset");
    check("pre_reset.pulse", 32'(cpu_en_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset.en", 32'(cpu_en_o), 32'd0);
    check("mid_reset.state", 32'(state_o), 32'(ST_IDLE));
    check("mid_reset.icount", 32'(icount_o), 32'd0);
    @(negedge clk);
    check("held_reset.state", 32'(state_o), 32'(ST_IDLE));
    check("held_reset.en", 32'(cpu_en_o), 32'd0);
    run_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();

    // bouncy key press, long hold, release
    n_pulses = 0;
    for (int i = 0; i < 22; i++) begin
      step_n_i = (i == 1 || i >= 12) ? 1'b1 : 1'b0;
      tick("step");
    end
    check("step.pulses", 32'(n_pulses), 32'd1);
    check("step.icount", 32'(icount_o), 32'd1);
    check("step.state", 32'(state_o), 32'(ST_IDLE));

    // run switch and step request arrive on the same edge
    found = 0;
    step_n_i = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_step_req) found = 1;
      else tick("prio_wait");
    end
    check("prio.found", 32'(found), 32'd1);
    run_i = 1'b1;
    n_pulses = 0;
    tick("prio");
    check("prio.state", 32'(state_o), 32'(ST_RUN));
    repeat (2) tick("prio_run");
    check("prio.pulses", 32'(n_pulses), 32'd0);
    run_i = 1'b0;
    step_n_i = 1'b1;
    repeat (10) tick("prio_release");
    check("prio.icount", 32'(icount_o), 32'd1);

    // breakpoint at 0x05 with PC following the pulses
    bp_en_i = 1'b1; bp_addr_i = 8'h05; pc_i = '0; auto_pc = 1'b1; pc_mask = 8'hFF;
    n_pulses = 0;
    run_i = 1'b1;
    repeat (20) tick("bp_run");
    check("bp.pulses", 32'(n_pulses), BP_ON ? 32'd5 : 32'd6);
    check("bp.state", 32'(state_o), BP_ON ? 32'(ST_BREAK) : 32'(ST_RUN));
    check("bp.hit", 32'(bp_hit_o), 32'(BP_ON));
    check("bp.pc", 32'(pc_i), BP_ON ? 32'd5 : 32'd6);
    n_pulses = 0;
    step_n_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_state == ST_STEP) run_i = 1'b0;
      tick("bp_step");
    end
    check("bp_step.pulses", 32'(n_pulses), BP_ON ? 32'd1 : 32'd3);
    check("bp_step.state", 32'(state_o), BP_ON ? 32'(ST_IDLE) : 32'(ST_RUN));
    check("bp_step.pc", 32'(pc_i), BP_ON ? 32'd6 : 32'd9);
    run_i = 1'b0;
    step_n_i = 1'b1;
    n_pulses = 0;
    repeat (10) tick("bp_release");
    check("bp_release.pulses", 32'(n_pulses), 32'd0);
    auto_pc = 1'b0;
    pc_i = 8'h05;
    run_i = 1'b1;
    n_pulses = 0;
    repeat (4) tick("skip_bp");
    check("skip_bp.pulses", 32'(n_pulses), 32'd1);
    check("skip_bp.state", 32'(state_o), 32'(ST_RUN));
    repeat (3) tick("rebreak");
    check("rebreak.state", 32'(state_o), BP_ON ? 32'(ST_BREAK) : 32'(ST_RUN));
    check("rebreak.hit", 32'(bp_hit_o), 32'(BP_ON));
    check("rebreak.pulses", 32'(n_pulses), BP_ON ? 32'd1 : 32'd2);
    run_i = 1'b0;
    bp_en_i = 1'b0;
    repeat (2) tick("bp_exit");

    // instruction counter wrap
    run_i = 1'b1;
    for (int i = 0; i < 1000 && m_icount != 8'hFF; i++) tick("wrap_fill");
    check("wrap.before", 32'(icount_o), 32'hFF);
    wrapped = 0;
    for (int i = 0; i < 4 && !wrapped; i++) begin
      tick("wrap_edge");
      if (m_en) wrapped = 1;
    end
    check("wrap.after", 32'(icount_o), 32'h00);
    run_i = 1'b0;
    repeat (2) tick("wrap_exit");

    // random traffic against the model
    pc_mask = 8'h07; auto_pc = 1'b1; bp_en_i = 1'b1; bp_addr_i = 8'h03; pc_i = '0;
    key_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_i = ~run_i;
      if (key_hold == 0) begin
        step_n_i = 1'($urandom_range(0, 1));
        key_hold = $urandom_range(1, 12);
      end else begin
        key_hold--;
      end
      if ($urandom_range(0, 99) == 0) bp_en_i = ~bp_en_i;
      if ($urandom_range(0, 199) == 0) bp_addr_i = PC_W'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) pc_i = PC_W'($urandom_range(0, 7));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
